// File: rtl/sram_bus_arbiter_pkg.sv
// sram_bus_arbiter_pkg: FSM state and owner encodings plus the strobe-width helper shared by the arbiter and its interface
package sram_bus_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/sram_bus_arbiter_if.sv
// sram_bus_arbiter_if: IF/MEM requester, stall and sram-like bus signals; master = arbiter side, slave = pipeline/bridge side
interface sram_bus_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  import sram_bus_arbiter_pkg::*;
  localparam int STRB_W = strb_w(DATA_W);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_done;
  logic              data_req;
  logic              data_wr;
  logic [STRB_W-1:0] data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_done;
  logic              pipe_stall;
  logic              bus_req;
  logic              bus_wr;
  logic [STRB_W-1:0] bus_wstrb;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;
  logic              stallreq_for_bus;
  modport master (
    input  inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
           pipe_stall, bus_addr_ok, bus_data_ok, bus_rdata,
    output inst_rdata, inst_done, data_rdata, data_done, bus_req, bus_wr, bus_wstrb,
           bus_addr, bus_wdata, stallreq_for_bus
  );
  modport slave (
    output inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
           pipe_stall, bus_addr_ok, bus_data_ok, bus_rdata,
    input  inst_rdata, inst_done, data_rdata, data_done, bus_req, bus_wr, bus_wstrb,
           bus_addr, bus_wdata, stallreq_for_bus
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one sram-like bus between IF fetch and MEM load/store; ports clk, rst (sync, active-high), io_bif (master modport)
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
(
  input logic clk,
  input logic rst,
  sram_bus_arbiter_if.master io_bif
);
  localparam int AW = $bits(io_bif.bus_addr);
  localparam int DW = $bits(io_bif.bus_wdata);
  localparam int SW = $bits(io_bif.bus_wstrb);
  state_t r_state, w_next;
  owner_t r_owner, r_last;
  logic          r_wr;
  logic [SW-1:0] r_wstrb;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_inst_served, r_data_served;
  logic [DW-1:0] r_inst_rdata_q, r_data_rdata_q;
  logic w_inst_eff, w_data_eff, w_grant, w_grant_data, w_complete, w_inst_done, w_data_done;
  assign w_inst_eff   = io_bif.inst_req & ~r_inst_served;
  assign w_data_eff   = io_bif.data_req & ~r_data_served;
  assign w_grant      = r_state == S_IDLE && (w_inst_eff || w_data_eff);
  assign w_grant_data = w_data_eff & (~w_inst_eff | (r_last == OWN_INST));
  always_comb begin
    w_complete = (r_state == S_ADDR && io_bif.bus_addr_ok && io_bif.bus_data_ok) ||
                 (r_state == S_DATA && io_bif.bus_data_ok);
    w_next = w_complete ? S_IDLE :
             w_grant ? S_ADDR :
             (r_state == S_ADDR && io_bif.bus_addr_ok) ? S_DATA : r_state;
    w_inst_done = ~rst & w_complete & (r_owner == OWN_INST);
    w_data_done = ~rst & w_complete & (r_owner == OWN_DATA);
    io_bif.bus_req          = ~rst & (r_state == S_ADDR);
    io_bif.bus_wr           = ~rst & r_wr;
    io_bif.bus_wstrb        = rst ? '0 : r_wstrb;
    io_bif.bus_addr         = rst ? '0 : r_addr;
    io_bif.bus_wdata        = rst ? '0 : r_wdata;
    io_bif.inst_done        = w_inst_done;
    io_bif.data_done        = w_data_done;
    io_bif.inst_rdata       = rst ? '0 : w_inst_done ? io_bif.bus_rdata : r_inst_rdata_q;
    io_bif.data_rdata       = rst ? '0 : (w_data_done & ~r_wr) ? io_bif.bus_rdata : r_data_rdata_q;
    io_bif.stallreq_for_bus = ~rst & ((w_inst_eff & ~w_inst_done) | (w_data_eff & ~w_data_done));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_owner        <= OWN_INST;
      r_last         <= OWN_INST;
      r_wr           <= 1'b0;
      r_wstrb        <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_inst_served  <= 1'b0;
      r_data_served  <= 1'b0;
      r_inst_rdata_q <= '0;
      r_data_rdata_q <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_owner <= w_grant_data ? OWN_DATA : OWN_INST;
        r_wr    <= w_grant_data & io_bif.data_wr;
        r_wstrb <= w_grant_data ? io_bif.data_wstrb : '0;
        r_addr  <= w_grant_data ? io_bif.data_addr : io_bif.inst_addr;
        r_wdata <= w_grant_data ? io_bif.data_wdata : '0;
      end
      if (w_complete) r_last <= r_owner;
      // served flags only survive while the pipeline is held, so a held request is not re-issued
      r_inst_served <= io_bif.pipe_stall & (r_inst_served | w_inst_done);
      r_data_served <= io_bif.pipe_stall & (r_data_served | w_data_done);
      if (w_inst_done) r_inst_rdata_q <= io_bif.bus_rdata;
      if (w_data_done & ~r_wr) r_data_rdata_q <= io_bif.bus_rdata;
    end
  end
endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one sram-like bus master port between the IF-stage instruction fetch and the MEM-stage load/store.
- Sequences each transaction through an address phase and a data phase.
- Raises a stall request to the pipeline stall controller until every pending requester has been served.
- Sits between the pipeline stages and the external bus bridge.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte-strobe width = DATA_W/8)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
inst_req  in  1  IF fetch request, held until served
inst_addr  in  ADDR_W  fetch address
inst_rdata  out  DATA_W  fetched word
inst_done  out  1  fetch-complete pulse
data_req  in  1  MEM access request, held until served
data_wr  in  1  1 = store, 0 = load
data_wstrb  in  DATA_W/8  store byte strobes
data_addr  in  ADDR_W  access address
data_wdata  in  DATA_W  store data
data_rdata  out  DATA_W  load data
data_done  out  1  access-complete pulse
pipe_stall  in  1  pipeline held this cycle (any cause)
bus_req  out  1  bus request
bus_wr  out  1  bus write
bus_wstrb  out  DATA_W/8  bus strobes
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_addr_ok  in  1  address accepted
bus_data_ok  in  1  data phase complete
bus_rdata  in  DATA_W  bus read data
stallreq_for_bus  out  1  stall request to the stall controller

Behaviour:
- FSM states: IDLE, ADDR, DATA. Registers: owner (INST/DATA), last_owner, latched request fields (wr, wstrb, addr, wdata), inst_served, data_served, inst_rdata_q, data_rdata_q.
- Effective requests: inst_eff = inst_req & ~inst_served; data_eff = data_req & ~data_served.

Grant (IDLE, at the clock edge):
- Both effective: grant DATA, unless last_owner == DATA, in which case grant INST.
- Only one effective: grant it.
- On grant: latch the owner's fields and go to ADDR.
- Grant-to-bus_req latency is 1 cycle.

ADDR state:
- bus_req = 1; bus_* driven from the latched fields.
- bus_addr_ok = 1 and bus_data_ok = 0 -> go to DATA.
- bus_addr_ok = 1 and bus_data_ok = 1 in the same cycle -> complete the transaction (as below) and go to IDLE.

DATA state:
- bus_req = 0.
- bus_data_ok = 1 -> complete and go to IDLE.

Completion:
- The owner's done output is high combinationally in the completing cycle.
- The owner's rdata output passes bus_rdata through in that cycle and captures it into *_rdata_q. Outside the done cycle, rdata outputs show *_rdata_q.
- The owner's served flag is set; last_owner is set to owner.
- Stores pulse data_done; data_rdata_q is not updated.

Stall and served flags:
- stallreq_for_bus = (inst_eff & ~inst_done) | (data_eff & ~data_done).
- stallreq_for_bus does not depend combinationally on pipe_stall (no loop through the stall controller).
- Both served flags clear at any edge with pipe_stall = 0. This prevents re-issuing a held request while another stage keeps the pipeline stalled.

Reset:
- Outputs: bus_req 0, bus_wr 0, bus_wstrb 0, bus_addr 0, bus_wdata 0, inst_done 0, data_done 0, inst_rdata 0, data_rdata 0, stallreq_for_bus 0 while rst.
- State: IDLE, served flags 0, last_owner INST, rdata_q 0.
- Reset mid-transaction abandons it immediately. The bus bridge shares rst.

Boundary cases:
- A requester deasserting its request in IDLE before grant: no transaction is issued.
- Requests are ignored while state ≠ IDLE; latched fields stay stable through ADDR/DATA.
- bus_data_ok in IDLE: ignored.

Decomposition:
- Shared package: FSM state encoding, owner encoding, and the strobe-width constant DATA_W/8, added alongside the existing defines header.
- No sub-module needed. Optionally factor a one-entry request latch (req_latch) used for the grant capture.

Test Plan:
1. Single load: data_req = 1, addr 0x1000, wr 0; bus_addr_ok in cycle 2, bus_data_ok = 1 with rdata 0xDEADBEEF in cycle 4 -> bus_req high cycles 1–2; data_done and data_rdata = 0xDEADBEEF in cycle 4; stallreq_for_bus low from cycle 4.
2. Simultaneous inst_req (0xBFC00000) and data_req (store 0x55AA55AA, wstrb 0xF), pipe_stall = 1 until both served -> data transaction issued first, then inst; no third transaction; stallreq drops in the cycle of inst_done; served flags clear at the next edge with pipe_stall = 0.
3. bus_addr_ok and bus_data_ok in the same ADDR cycle -> done pulse in that cycle; FSM back in IDLE next cycle; no extra bus_req.
4. Served request held while pipe_stall = 1 for 5 cycles -> bus_req stays 0; no repeat access; after pipe_stall = 0 with the new inst_req, a new fetch is issued.
5. Assert rst while in DATA -> next cycle all outputs 0, state IDLE; a late bus_data_ok is ignored with no done pulse.
6. Back-to-back data_req with inst_req pending -> after one data transaction, inst is granted (last_owner alternation); no starvation of inst over 10 transactions.
